// File: rtl/pcpu_pkg.sv
// pcpu_pkg: opcode map, run-control state and instruction-field decode helpers
// shared by the pcpu datapath decoder and its pipeline control.
package pcpu_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} pctl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic writes_r1(input logic [4:0] op);
        return op inside {OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI,
                          OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
    endfunction

    function automatic logic reads_r1(input logic [4:0] op);
        return op inside {OP_STORE, OP_LDIH, OP_ADDI, OP_SUBI, OP_JMPR,
                          OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};
    endfunction

    function automatic logic reads_r2(input logic [4:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
                          OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
    endfunction

    function automatic logic reads_r3(input logic [4:0] op);
        return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/pcpu_fwd_unit.sv
// pcpu_fwd_unit: operand forwarding selects for the ID stage; EX results win
// over MEM results, and a LOAD in EX cannot forward (its data is not ready yet).
module pcpu_fwd_unit
    import pcpu_pkg::*;
(
    input  logic [15:0] id_ir,
    input  logic [15:0] ex_ir,
    input  logic [15:0] mem_ir,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);
    logic [4:0] id_op, ex_op, mem_op;
    logic [2:0] a_reg, b_reg;
    logic       ex_fwd, mem_fwd;
    logic       unused_bits;

    assign id_op  = id_ir[15:11];
    assign ex_op  = ex_ir[15:11];
    assign mem_op = mem_ir[15:11];

    // Every r1 reader except STORE uses r1 as its A operand; STORE's r1 is the B operand.
    assign a_reg = (reads_r1(id_op) && id_op != OP_STORE) ? id_ir[10:8] : id_ir[6:4];
    assign b_reg = (id_op == OP_STORE) ? id_ir[10:8] : id_ir[2:0];

    assign ex_fwd  = writes_r1(ex_op) && ex_op != OP_LOAD;
    assign mem_fwd = writes_r1(mem_op);

    assign fwd_a = (ex_fwd && ex_ir[10:8] == a_reg) ? FWD_EX :
                   (mem_fwd && mem_ir[10:8] == a_reg) ? FWD_MEM : FWD_RF;
    assign fwd_b = (ex_fwd && ex_ir[10:8] == b_reg) ? FWD_EX :
                   (mem_fwd && mem_ir[10:8] == b_reg) ? FWD_MEM : FWD_RF;

    assign unused_bits = ^{id_ir[7], id_ir[3], ex_ir[7:0], mem_ir[7:0]};
endmodule

// File: rtl/pcpu_pipe_ctrl.sv
// pcpu_pipe_ctrl: run-control FSM, load-use/branch interlocks, forwarding and
// performance counters for the five-stage pcpu pipeline.
module pcpu_pipe_ctrl
    import pcpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [15:0]      id_ir,
    input  logic [15:0]      ex_ir,
    input  logic [15:0]      mem_ir,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    pctl_state_t   state, state_n;
    logic [DW-1:0] dcnt;
    logic [4:0]    id_op, ex_op;
    logic [1:0]    fa, fb;
    logic          load_use, in_run, in_drain, active, stall, drain_done;

    assign id_op = id_ir[15:11];
    assign ex_op = ex_ir[15:11];

    assign load_use = ex_op == OP_LOAD &&
                      ((reads_r1(id_op) && id_ir[10:8] == ex_ir[10:8]) ||
                       (reads_r2(id_op) && id_ir[6:4]  == ex_ir[10:8]) ||
                       (reads_r3(id_op) && id_ir[2:0]  == ex_ir[10:8]));

    assign running    = state == S_RUN || state == S_DRAIN;
    assign halted     = state == S_HALT;
    assign in_run     = enable && state == S_RUN;
    assign in_drain   = enable && state == S_DRAIN;
    assign active     = in_run || in_drain;
    assign drain_done = dcnt == DRAIN_LAST;

    // A taken branch overrides both the load-use stall and the drain freeze.
    assign flush        = active && branch_taken;
    assign stall        = in_run && load_use && !branch_taken;
    assign pc_we        = flush || (in_run && !load_use);
    assign if_id_we     = pc_we;
    assign id_ex_bubble = stall || (in_drain && !branch_taken);

    pcpu_fwd_unit u_fwd (
        .id_ir (id_ir),
        .ex_ir (ex_ir),
        .mem_ir(mem_ir),
        .fwd_a (fa),
        .fwd_b (fb)
    );

    assign fwd_a = running ? fa : FWD_RF;
    assign fwd_b = running ? fb : FWD_RF;

    always_comb begin
        state_n = (state == S_IDLE && start)                             ? S_RUN   :
                  (state == S_RUN && id_op == OP_HALT && !branch_taken) ? S_DRAIN :
                  (state == S_DRAIN && branch_taken)                     ? S_RUN   :
                  (state == S_DRAIN && drain_done)                       ? S_HALT  : state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dcnt      <= '0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (enable) begin
            state <= state_n;
            dcnt  <= (state == S_DRAIN && !branch_taken && !drain_done) ? dcnt + 1'b1 : '0;
            if (active && !(&cycle_cnt))
                cycle_cnt <= cycle_cnt + 1'b1;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/pcpu_pipe_ctrl.md
# pcpu_pipe_ctrl

Pipeline run-control and interlock unit for the 16-bit five-stage `pcpu` datapath (IF, ID, EX, MEM, WB).
- Sequences the core from `start` through execution to a drained halt.
- Detects load-use and taken-branch hazards, and drives the pipeline-register write enables, bubble and flush controls.
- Computes the operand-forwarding selects.
- Keeps cycle and stall counters.

It sits between the top-level `CPU` wrapper, which supplies `enable`/`start`, and the `pcpu` datapath.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN after HALT is decoded (EX, MEM, WB emptying).
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global freeze; 0 holds the whole core.
- `start`  in  1  one-cycle start pulse.
- `id_ir`, `ex_ir`, `mem_ir`  in  16 each  instruction registers of ID, EX and MEM.
- `branch_taken`  in  1  EX-stage branch/jump resolved taken this cycle.
- `pc_we`, `if_id_we`  out  1 each  PC and IF/ID register write enables.
- `id_ex_bubble`  out  1  load NOP into the ID/EX register instead of `id_ir`.
- `flush`  out  1  load NOP into IF/ID and ID/EX.
- `fwd_a`, `fwd_b`  out  2 each  operand source selects: 00 register file, 01 EX result (`reg_C`), 10 MEM result (`reg_C1`).
- `running`  out  1  state is RUN or DRAIN.
- `halted`  out  1  state is HALT.
- `cycle_cnt`, `stall_cnt`  out  `CNT_W` each  performance counters.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: normal execution.
  - DRAIN: HALT is held in ID while older instructions retire.
  - HALT: terminal.
- Transitions (taken only when `enable`=1):
  - IDLE→RUN on `start`.
  - RUN→DRAIN when `id_ir[15:11]`=HALT (00001) and `branch_taken`=0.
  - DRAIN→RUN when `branch_taken`=1, because the HALT was on the wrong path.
  - DRAIN→HALT when the drain counter reaches `DRAIN_CYCLES`-1.
  - HALT is left only by reset.
  - `start` in RUN, DRAIN or HALT is ignored.
- Opcode field is `ir[15:11]`; register fields are r1=`ir[10:8]`, r2=`ir[6:4]`, r3=`ir[2:0]`.
- Writers of gr[r1]: LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA. CMP, STORE, branches, NOP and HALT do not write.
- Reads of r2: LOAD, STORE, all register ALU ops and shifts.
- Reads of r3: ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR.
- Reads of r1: STORE, LDIH, ADDI, SUBI, JMPR, BZ..BNC.
- Load-use stall: `ex_ir` is LOAD, and `id_ir` reads `ex_ir` r1 through any of its read fields. Response: `pc_we`=`if_id_we`=0 and `id_ex_bubble`=1 for one cycle. `stall_cnt` increments.
- Flush: `branch_taken`=1 gives `flush`=1. Flush has priority over the load-use stall; `pc_we`=1 so the target loads.
- DRAIN outputs: `pc_we`=`if_id_we`=0 and `id_ex_bubble`=1 every cycle.
- Forwarding, applied separately to operand A and operand B:
  - Operand A is r2, or r1 for LDIH, ADDI, SUBI, JMPR and the branches. Operand B is r3, or r1 for STORE.
  - Select 01 if the operand register matches the destination of a non-LOAD writer in EX.
  - Otherwise select 10 if it matches the destination of any writer in MEM.
  - Otherwise select 00. EX has priority over MEM.
- Counters saturate at all-ones.
  - `cycle_cnt` counts cycles in RUN or DRAIN with `enable`=1.
  - `stall_cnt` counts load-use stall cycles.

## Timing
- Reset (async assert, sync release): state=IDLE, drain counter=0, `cycle_cnt`=`stall_cnt`=0.
- Outputs while IDLE or HALT: `pc_we`=`if_id_we`=0, `id_ex_bubble`=`flush`=0, `fwd_*`=00, `running`=0. `halted`=1 only in HALT.
- State, counters, `running` and `halted` are registered.
- Stall, flush, write-enable and forward outputs are combinational from the current IRs and the state, valid in the same cycle.
- `start` sampled high in IDLE gives `running`=1 and `pc_we`=1 on the next cycle.
- `enable`=0: all enables, bubble and flush are 0; state and counters hold. Forward selects still follow the IRs.
- HALT decoded in cycle N gives `halted`=1 in cycle N+1+`DRAIN_CYCLES`, provided no taken branch occurs.
- Reset mid-DRAIN or mid-stall returns to IDLE immediately.

## Structure
- Package `pcpu_pkg`:
  - opcode localparams (NOP..BNC);
  - state enum `pctl_state_t`;
  - fwd select constants;
  - functions `writes_r1`, `reads_r1`, `reads_r2`, `reads_r3`.
- The package is shared with the `pcpu` datapath decoder.
- One natural sub-module: `pcpu_fwd_unit`, the combinational forwarding selects. FSM, hazard logic and counters stay in `pcpu_pipe_ctrl`.

## Test plan
- Start sequence: reset low 10 ns, release, pulse `start` → `running`=1 and `pc_we`=1 next cycle; `cycle_cnt` increments from 0.
- Load-use: `ex_ir`=LOAD gr1 and `id_ir`=ADD gr3,gr1,gr2 → one cycle of `pc_we`=0, `id_ex_bubble`=1; `stall_cnt`=1.
- Forwarding:
  - `ex_ir`=ADD gr4,…, `mem_ir`=SUB gr4,…, `id_ir`=ADD gr5,gr4,gr4 → `fwd_a`=`fwd_b`=01.
  - With `ex_ir`=NOP → `fwd_a`=`fwd_b`=10.
- Branch priority: `branch_taken`=1 together with a load-use condition → `flush`=1, `pc_we`=1, `id_ex_bubble`=0; `stall_cnt` unchanged.
- Halt drain: HALT enters ID at cycle N → `halted`=1 at N+4. A `branch_taken` at N+1 instead returns to RUN with `halted`=0.
- Freeze: `enable`=0 for 5 cycles mid-RUN → all enables 0, `cycle_cnt` unchanged; execution resumes seamlessly.
